// File: rtl/rf_pkg.sv
// Shared register-file definitions: write-back source selects and the
// clear/ready state encoding. The control unit imports this package too.
package rf_pkg;

    // Write-back source select codes (rf_wsel)
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_EXT = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_DAM = 2'd3;

    // Register file state: sweeping zeros into the array, or usable
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rf_wb_mux.sv
// 4:1 write-back source select producing the data that goes to the write port.
module rf_wb_mux
    import rf_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      sel,
    input  logic [XLEN-1:0] alu_c,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc4,
    input  logic [XLEN-1:0] dram,
    output logic [XLEN-1:0] wd
);

    // Pick the write-back candidate named by sel
    always_comb begin
        wd = alu_c;
        case (sel)
            WB_ALU:  wd = alu_c;
            WB_EXT:  wd = imm;
            WB_PC4:  wd = pc4;
            WB_DAM:  wd = dram;
            default: wd = alu_c;
        endcase
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-back select, same-cycle bypass,
// a pending-write scoreboard and a one-entry-per-cycle clear sweep. The
// storage array has no reset so it can map onto distributed RAM; the sweep
// is what zeroes it.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [NRD*AW-1:0]   rR,
    output logic [NRD*XLEN-1:0] rD,
    output logic [NRD-1:0]      rbusy,
    input  logic                we,
    input  logic [AW-1:0]       wR,
    input  logic [1:0]          rf_wsel,
    input  logic [XLEN-1:0]     alu_c,
    input  logic [XLEN-1:0]     imm,
    input  logic [XLEN-1:0]     pc4,
    input  logic [XLEN-1:0]     dram,
    output logic [XLEN-1:0]     wD,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    output logic                ready
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    rf_state_e        state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [NREG-1:0]  busy_q, busy_d;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [XLEN-1:0]  wr_data;

    logic [XLEN-1:0]  regs_q [NREG];

    rf_wb_mux #(
        .XLEN (XLEN)
    ) u_wb_mux (
        .sel   (rf_wsel),
        .alu_c (alu_c),
        .imm   (imm),
        .pc4   (pc4),
        .dram  (dram),
        .wd    (wD)
    );

    assign ready = (state_q == ST_READY);

    // Next state, sweep index, scoreboard update and the single array write port
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        wr_en   = 1'b0;
        wr_addr = idx_q;
        wr_data = '0;
        if (state_q == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = idx_q;
            wr_data = '0;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
                state_d = ST_READY;
            end
        end else begin
            if (flush) begin
                // The array is about to be swept, so a write on this edge is pointless
                state_d = ST_CLEAR;
                idx_d   = '0;
                busy_d  = '0;
            end else begin
                if (we && (wR != '0)) begin
                    wr_en        = 1'b1;
                    wr_addr      = wR;
                    wr_data      = wD;
                    busy_d[wR]   = 1'b0;
                end
                // Applied after the clear so a newer producer keeps the bit set
                if (issue_valid && (issue_rd != '0)) begin
                    busy_d[issue_rd] = 1'b1;
                end
            end
        end
    end

    // Control state: FSM, sweep index and scoreboard bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
        end
    end

    // Storage array, deliberately without reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Read ports: zero register, forwarding of the in-flight write, pending flags
    always_comb begin
        logic [AW-1:0] ra;
        logic          fwd;
        rD    = '0;
        rbusy = '0;
        ra    = '0;
        fwd   = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            ra  = rR[i*AW +: AW];
            fwd = (BYPASS != 0) && we && (wR == ra);
            if (ready && (ra != '0)) begin
                rD[i*XLEN +: XLEN] = fwd ? wD : regs_q[ra];
                rbusy[i]           = busy_q[ra] && !fwd;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one 4-port bypassing instance and one
// 1-port non-bypassing instance driven with the same stimulus.
module tb_regfile_mp;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_EXT = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_DAM = 2'd3;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [19:0]  rr_a;
    logic [127:0] rd_a;
    logic [3:0]   rbusy_a;
    logic [31:0]  rd_b;
    logic [0:0]   rbusy_b;
    logic         we;
    logic [4:0]   wr;
    logic [1:0]   wsel;
    logic [31:0]  alu_c, imm, pc4, dram;
    logic [31:0]  wd_a, wd_b;
    logic         issue_valid;
    logic [4:0]   issue_rd;
    logic         ready_a, ready_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(4), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .rR(rr_a), .rD(rd_a), .rbusy(rbusy_a),
        .we(we), .wR(wr), .rf_wsel(wsel), .alu_c(alu_c), .imm(imm), .pc4(pc4), .dram(dram),
        .wD(wd_a), .issue_valid(issue_valid), .issue_rd(issue_rd), .ready(ready_a)
    );

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .rR(rr_a[4:0]), .rD(rd_b), .rbusy(rbusy_b),
        .we(we), .wR(wr), .rf_wsel(wsel), .alu_c(alu_c), .imm(imm), .pc4(pc4), .dram(dram),
        .wD(wd_b), .issue_valid(issue_valid), .issue_rd(issue_rd), .ready(ready_b)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [1:0]  wsel;
        logic [31:0] alu, imm, pc4, dram;
        logic [4:0]  rr0, rr1;
        logic        iv;
        logic [4:0]  ird;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd0a;
        logic        exp_rb1a;
        logic [31:0] exp_rd0b;
        logic        exp_rb0b;
    } vec_t;

    vec_t vecs [11];

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        we          = v.we;
        wr          = v.wr;
        wsel        = v.wsel;
        alu_c       = v.alu;
        imm         = v.imm;
        pc4         = v.pc4;
        dram        = v.dram;
        rr_a        = {5'd0, 5'd0, v.rr1, v.rr0};
        issue_valid = v.iv;
        issue_rd    = v.ird;
    endtask

    task automatic idle_inputs();
        we = 1'b0; wr = '0; wsel = WB_ALU; alu_c = '0; imm = '0; pc4 = '0; dram = '0;
        issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
    endtask

    // Count out a full sweep after reset release or a flush edge
    task automatic sweep_check(input string tag);
        for (int c = 1; c <= 32; c++) begin
            step();
            check_output({tag, "_ready_a"}, {127'd0, ready_a}, {127'd0, (c == 32)});
            if (c == 32) check_output({tag, "_ready_b"}, {127'd0, ready_b}, 128'd1);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // WD=alu/imm/pc4/dram as picked by wsel
        vecs[0]  = '{1'b1, 5'd5, WB_ALU, 32'hDEADBEEF, 32'h11, 32'h22, 32'h33, 5'd5, 5'd0, 1'b0, 5'd0,
                     32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 5'd0, WB_EXT, 32'h1, 32'h2, 32'h3, 32'h4, 5'd5, 5'd0, 1'b0, 5'd0,
                     32'h2, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 5'd0, WB_EXT, 32'h5, 32'h1234, 32'h6, 32'h7, 5'd0, 5'd0, 1'b0, 5'd0,
                     32'h1234, 32'h0, 1'b0, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 5'd0, WB_PC4, 32'h8, 32'h9, 32'hCAFE0004, 32'hA, 5'd0, 5'd0, 1'b0, 5'd0,
                     32'hCAFE0004, 32'h0, 1'b0, 32'h0, 1'b0};
        vecs[4]  = '{1'b0, 5'd0, WB_DAM, 32'h1, 32'h2, 32'h3, 32'h77, 5'd7, 5'd7, 1'b1, 5'd7,
                     32'h77, 32'h0, 1'b0, 32'h0, 1'b0};
        vecs[5]  = '{1'b0, 5'd0, WB_ALU, 32'h0, 32'h2, 32'h3, 32'h4, 5'd7, 5'd7, 1'b0, 5'd0,
                     32'h0, 32'h0, 1'b1, 32'h0, 1'b1};
        vecs[6]  = '{1'b1, 5'd7, WB_ALU, 32'h700, 32'h2, 32'h3, 32'h4, 5'd7, 5'd7, 1'b0, 5'd0,
                     32'h700, 32'h700, 1'b0, 32'h0, 1'b1};
        vecs[7]  = '{1'b0, 5'd0, WB_ALU, 32'h0, 32'h0, 32'h0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0,
                     32'h0, 32'h700, 1'b0, 32'h700, 1'b0};
        vecs[8]  = '{1'b1, 5'd9, WB_ALU, 32'h900, 32'h0, 32'h0, 32'h0, 5'd9, 5'd9, 1'b1, 5'd9,
                     32'h900, 32'h900, 1'b0, 32'h0, 1'b0};
        vecs[9]  = '{1'b0, 5'd0, WB_ALU, 32'h0, 32'h0, 32'h0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0,
                     32'h0, 32'h900, 1'b1, 32'h900, 1'b1};
        vecs[10] = '{1'b1, 5'd3, WB_DAM, 32'h0, 32'h0, 32'h0, 32'h55, 5'd3, 5'd9, 1'b0, 5'd0,
                     32'h55, 32'h55, 1'b1, 32'h0, 1'b0};

        idle_inputs();
        rr_a = {5'd4, 5'd3, 5'd2, 5'd5};
        rst  = 1'b1;
        step();
        step();
        check_output("rst_ready", {126'd0, ready_b, ready_a}, 128'd0);
        check_output("rst_rd_a", rd_a, 128'd0);
        check_output("rst_rbusy_a", {124'd0, rbusy_a}, 128'd0);
        check_output("rst_rd_b", {96'd0, rd_b}, 128'd0);
        rst = 1'b0;
        sweep_check("init");

        for (int r = 1; r < 32; r++) begin
            rr_a = {4{r[4:0]}};
            #1;
            check_output("sweep_zero_a", rd_a, 128'd0);
            check_output("sweep_zero_b", {96'd0, rd_b}, 128'd0);
        end
        step();

        for (int k = 0; k < 11; k++) begin
            apply_stimulus(vecs[k]);
            #1;
            check_output($sformatf("v%0d_wd_a", k), {96'd0, wd_a}, {96'd0, vecs[k].exp_wd});
            check_output($sformatf("v%0d_wd_b", k), {96'd0, wd_b}, {96'd0, vecs[k].exp_wd});
            check_output($sformatf("v%0d_rd0_a", k), {96'd0, rd_a[31:0]}, {96'd0, vecs[k].exp_rd0a});
            check_output($sformatf("v%0d_rbusy1_a", k), {127'd0, rbusy_a[1]}, {127'd0, vecs[k].exp_rb1a});
            check_output($sformatf("v%0d_rd0_b", k), {96'd0, rd_b}, {96'd0, vecs[k].exp_rd0b});
            check_output($sformatf("v%0d_rbusy0_b", k), {127'd0, rbusy_b[0]}, {127'd0, vecs[k].exp_rb0b});
            step();
        end

        // Four aliased ports on register 3, then on the pending register 9
        idle_inputs();
        rr_a = {4{5'd3}};
        #1;
        check_output("alias_rd_a", rd_a, {4{32'h55}});
        check_output("alias_rd_b", {96'd0, rd_b}, 128'h55);
        rr_a = {4{5'd9}};
        #1;
        check_output("alias_rbusy_a", {124'd0, rbusy_a}, 128'hF);
        step();

        // Register 10 holds 0xAA and register 12 is pending before the flush
        we = 1'b1; wr = 5'd10; wsel = WB_ALU; alu_c = 32'hAA;
        issue_valid = 1'b1; issue_rd = 5'd12;
        step();
        idle_inputs();
        rr_a = {5'd5, 5'd9, 5'd12, 5'd10};
        #1;
        check_output("pre_flush_rd10", {96'd0, rd_a[31:0]}, 128'hAA);
        check_output("pre_flush_busy12", {127'd0, rbusy_a[1]}, 128'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_output("flush_ready", {126'd0, ready_b, ready_a}, 128'd0);
        check_output("flush_rd_zero", rd_a, 128'd0);

        // Writes, issues and extra flushes during the sweep must all be ignored
        for (int c = 1; c <= 32; c++) begin
            we = (c < 32); wr = 5'd10; wsel = WB_ALU; alu_c = 32'hBB;
            issue_valid = (c < 32); issue_rd = 5'd5;
            flush = (c >= 5 && c <= 10);
            step();
            check_output("fsweep_ready", {127'd0, ready_a}, {127'd0, (c == 32)});
        end
        idle_inputs();
        #1;
        check_output("post_flush_rd10", {96'd0, rd_a[31:0]}, 128'd0);
        check_output("post_flush_rd10_b", {96'd0, rd_b}, 128'd0);
        check_output("post_flush_rbusy", {124'd0, rbusy_a}, 128'd0);
        rr_a = {5'd3, 5'd7, 5'd9, 5'd3};
        #1;
        check_output("post_flush_rd3", {96'd0, rd_a[31:0]}, 128'd0);
        check_output("post_flush_rbusy2", {124'd0, rbusy_a}, 128'd0);

        // Reset in the middle of a sweep restarts it from index 0
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int c = 1; c < 15; c++) step();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_output("midsweep_rst_ready", {127'd0, ready_a}, 128'd0);
        step();
        rst = 1'b0;
        sweep_check("restart");
        rr_a = {5'd10, 5'd9, 5'd7, 5'd5};
        #1;
        check_output("restart_rbusy", {124'd0, rbusy_a}, 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
